// File: rtl/scratch_pkg.sv
// Shared defaults and small helpers for the scratch register file.
package scratch_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_ADDR_W  = $clog2(DEF_DEPTH);
    localparam int DEF_COUNT_W = DEF_ADDR_W + 1;

    // Where a read port takes its next value from.
    typedef enum logic [1:0] {
        SRC_MISS   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ARRAY  = 2'd2
    } rd_src_e;

    // The occupancy counter must represent 0..DEPTH inclusive.
    function automatic int count_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/scratch_mem.sv
// Plain DEPTH x WIDTH storage: one synchronous write port and two
// asynchronous read ports. It holds no validity information.
module scratch_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rd_a,
    output logic [WIDTH-1:0]  rd_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store write data; contents survive reset and clear.
    // NOTE: the array has no reset on purpose -- validity lives in separate
    // flags, so stale contents are harmless and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_a = mem[raddr_a];
    assign rd_b = mem[raddr_b];

endmodule

// File: rtl/scratch.sv
// Two-read-port scratch register file with per-entry valid flags,
// write-first bypass, registered read outputs and an occupancy count.
// rst_n is an active-high synchronous reset despite its name.
module scratch
    import scratch_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rhit_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rhit_b,
    output logic [ADDR_W:0]   count
);

    localparam int COUNT_W = count_w(ADDR_W);

    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0]   valid_post_clr;
    logic [DEPTH-1:0]   valid_next;
    logic [COUNT_W-1:0] count_next;
    logic [WIDTH-1:0]   mem_rd_a;
    logic [WIDTH-1:0]   mem_rd_b;
    logic               mem_we;
    rd_src_e            src_a;
    rd_src_e            src_b;

    // A write coincident with reset is discarded, including its array update.
    assign mem_we = we & ~rst_n;

    scratch_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rd_a    (mem_rd_a),
        .rd_b    (mem_rd_b)
    );

    // Clear applies before the write: reads and the count see post-clear flags.
    assign valid_post_clr = clr ? '0 : valid;

    // Next valid flags and occupancy: clear first, then mark the written entry.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_next = valid_post_clr;
        count_next = count;
        if (we) begin
            valid_next[waddr] = 1'b1;
        end
        if (clr) begin
            count_next = {{(COUNT_W-1){1'b0}}, we};
        end else if (we && !valid[waddr]) begin
            count_next = count + 1'b1;
        end
    end

    // Pick the source for each read port: bypass beats array, invalid is a miss.
    always_comb begin
        src_a = SRC_MISS;
        src_b = SRC_MISS;
        if (we && (raddr_a == waddr)) begin
            src_a = SRC_BYPASS;
        end else if (valid_post_clr[raddr_a]) begin
            src_a = SRC_ARRAY;
        end
        if (we && (raddr_b == waddr)) begin
            src_b = SRC_BYPASS;
        end else if (valid_post_clr[raddr_b]) begin
            src_b = SRC_ARRAY;
        end
    end

    // Valid flags and occupancy register; reset wins over clear and write.
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid <= '0;
            count <= '0;
        end else begin
            valid <= valid_next;
            count <= count_next;
        end
    end

    // Port A output register; holds its value while re_a is low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rdata_a <= '0;
            rhit_a  <= 1'b0;
        end else if (re_a) begin
            unique case (src_a)
                SRC_BYPASS: begin
                    rdata_a <= wdata;
                    rhit_a  <= 1'b1;
                end
                SRC_ARRAY: begin
                    rdata_a <= mem_rd_a;
                    rhit_a  <= 1'b1;
                end
                default: begin
                    rdata_a <= '0;
                    rhit_a  <= 1'b0;
                end
            endcase
        end
    end

    // Port B output register; holds its value while re_b is low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rdata_b <= '0;
            rhit_b  <= 1'b0;
        end else if (re_b) begin
            unique case (src_b)
                SRC_BYPASS: begin
                    rdata_b <= wdata;
                    rhit_b  <= 1'b1;
                end
                SRC_ARRAY: begin
                    rdata_b <= mem_rd_b;
                    rhit_b  <= 1'b1;
                end
                default: begin
                    rdata_b <= '0;
                    rhit_b  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scratch.sv
// Self-checking bench for scratch: a behavioural model compared every cycle,
// plus directed vectors with literal expectations.
module tb_scratch;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_a;
    logic              rhit_a;
    logic [WIDTH-1:0]  rdata_b;
    logic              rhit_b;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;

    scratch #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re_a    (re_a),
        .raddr_a (raddr_a),
        .re_b    (re_b),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rhit_a  (rhit_a),
        .rdata_b (rdata_b),
        .rhit_b  (rhit_b),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem   [DEPTH];
    bit          m_valid [DEPTH];
    logic [31:0] exp_rdata_a, exp_rdata_b;
    logic        exp_rhit_a, exp_rhit_b;
    logic [4:0]  exp_count;
    bit          model_ready = 1'b0;

    always @(posedge clk) begin : model
        bit          v_post [DEPTH];
        logic [31:0] ra, rb;
        logic        ha, hb;
        int          cnt;
        if (rst_n === 1'b1) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] <= 1'b0;
            exp_rdata_a <= 32'd0;
            exp_rdata_b <= 32'd0;
            exp_rhit_a  <= 1'b0;
            exp_rhit_b  <= 1'b0;
            exp_count   <= 5'd0;
            model_ready <= 1'b1;
        end else if (model_ready) begin
            for (int i = 0; i < DEPTH; i++) v_post[i] = clr ? 1'b0 : m_valid[i];
            if (re_a) begin
                if (we && raddr_a == waddr) begin ra = wdata; ha = 1'b1; end
                else if (v_post[raddr_a]) begin ra = m_mem[raddr_a]; ha = 1'b1; end
                else begin ra = 32'd0; ha = 1'b0; end
                exp_rdata_a <= ra;
                exp_rhit_a  <= ha;
            end
            if (re_b) begin
                if (we && raddr_b == waddr) begin rb = wdata; hb = 1'b1; end
                else if (v_post[raddr_b]) begin rb = m_mem[raddr_b]; hb = 1'b1; end
                else begin rb = 32'd0; hb = 1'b0; end
                exp_rdata_b <= rb;
                exp_rhit_b  <= hb;
            end
            if (we) begin
                v_post[waddr] = 1'b1;
                m_mem[waddr] <= wdata;
            end
            cnt = 0;
            for (int i = 0; i < DEPTH; i++) cnt += int'(v_post[i]);
            exp_count <= 5'(cnt);
            for (int i = 0; i < DEPTH; i++) m_valid[i] <= v_post[i];
        end
    end

    // Compare DUT against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        if (model_ready) begin
            check("rdata_a", rdata_a, exp_rdata_a);
            check("rhit_a", 32'(rhit_a), 32'(exp_rhit_a));
            check("rdata_b", rdata_b, exp_rdata_b);
            check("rhit_b", 32'(rhit_b), 32'(exp_rhit_b));
            check("count", 32'(count), 32'(exp_count));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;

        // Reset for three cycles, then release.
        repeat (3) cycle();
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_rhit_b", 32'(rhit_b), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b0;
        cycle();
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_rdata_b", rdata_b, 32'd0);

        // Write entry 3, read it next cycle.
        we = 1'b1; waddr = 4'd3; wdata = 32'h3F80_0000;
        cycle();
        idle(); re_a = 1'b1; raddr_a = 4'd3;
        cycle();
        check("wr3_rdata_a", rdata_a, 32'h3F80_0000);
        check("wr3_rhit_a", 32'(rhit_a), 32'd1);
        check("wr3_count", 32'(count), 32'd1);

        // Hold: re_a low keeps the previous value.
        idle(); cycle();
        check("hold_rdata_a", rdata_a, 32'h3F80_0000);

        // Write-first bypass on port B; port A misses on invalid entry 9.
        we = 1'b1; waddr = 4'd5; wdata = 32'h4049_0FDB;
        re_b = 1'b1; raddr_b = 4'd5; re_a = 1'b1; raddr_a = 4'd9;
        cycle();
        check("byp_rdata_b", rdata_b, 32'h4049_0FDB);
        check("byp_rhit_b", 32'(rhit_b), 32'd1);
        check("miss_rdata_a", rdata_a, 32'd0);
        check("miss_rhit_a", 32'(rhit_a), 32'd0);
        check("byp_count", 32'(count), 32'd2);

        // Both ports read the same address.
        idle(); re_a = 1'b1; re_b = 1'b1; raddr_a = 4'd5; raddr_b = 4'd5;
        cycle();
        check("same_rdata_a", rdata_a, 32'h4049_0FDB);
        check("same_rdata_b", rdata_b, 32'h4049_0FDB);

        // Fill all entries, then overwrite entry 0.
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 32'h1000_0000 + 32'(i);
            cycle();
        end
        check("full_count", 32'(count), 32'd16);
        we = 1'b1; waddr = 4'd0; wdata = 32'hDEAD_BEEF;
        cycle();
        check("overwrite_count", 32'(count), 32'd16);

        // Clear with a coincident port-B read of a formerly valid entry.
        idle(); clr = 1'b1; re_b = 1'b1; raddr_b = 4'd4;
        cycle();
        check("clr_count", 32'(count), 32'd0);
        check("clr_read_rhit_b", 32'(rhit_b), 32'd0);
        idle(); re_a = 1'b1; raddr_a = 4'd7;
        cycle();
        check("clr_rdata_a", rdata_a, 32'd0);
        check("clr_rhit_a", 32'(rhit_a), 32'd0);

        // Clear and write together, with a bypassed read of the same entry.
        idle(); clr = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 32'hC000_0000;
        re_a = 1'b1; raddr_a = 4'd2;
        cycle();
        check("clrwe_count", 32'(count), 32'd1);
        check("clrwe_byp_rhit_a", 32'(rhit_a), 32'd1);
        idle(); re_a = 1'b1; raddr_a = 4'd2; re_b = 1'b1; raddr_b = 4'd3;
        cycle();
        check("clrwe_rdata_a", rdata_a, 32'hC000_0000);
        check("clrwe_rhit_a", 32'(rhit_a), 32'd1);
        check("clrwe_stale_rhit_b", 32'(rhit_b), 32'd0);

        // Reset in the middle of continuous writes.
        idle();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 4'(i + 4); wdata = $urandom;
            re_a = 1'b1; raddr_a = 4'(i + 3);
            rst_n = (i == 3 || i == 4) ? 1'b1 : 1'b0;
            cycle();
            if (i == 4) begin
                check("midrst_count", 32'(count), 32'd0);
                check("midrst_rhit_a", 32'(rhit_a), 32'd0);
            end
        end
        // Writes after release (entries 9..11) are legal; reset again to wipe them.
        idle(); rst_n = 1'b1;
        cycle();
        rst_n = 1'b0;
        cycle();
        check("rel_count", 32'(count), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            re_a = 1'b1; raddr_a = 4'(a); re_b = 1'b1; raddr_b = 4'(DEPTH - 1 - a);
            cycle();
            check("rel_rhit_a", 32'(rhit_a), 32'd0);
            check("rel_rdata_a", rdata_a, 32'd0);
            check("rel_rhit_b", 32'(rhit_b), 32'd0);
        end

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 60; i++) begin
            clr     = ($urandom_range(0, 15) == 0);
            we      = $urandom_range(0, 1) == 1;
            waddr   = 4'($urandom_range(0, DEPTH - 1));
            wdata   = $urandom;
            re_a    = $urandom_range(0, 3) != 0;
            raddr_a = 4'($urandom_range(0, DEPTH - 1));
            re_b    = $urandom_range(0, 3) != 0;
            raddr_b = (i % 5 == 0) ? waddr : 4'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        idle();
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
